matrix_reader: RTL and testbench

- Synthesizable loader that accepts an n x n matrix of 32-bit words as a row-major stream over a valid/ready handshake.
- Deposits each word into a matrix buffer RAM (one write per word) and exposes the current row/column indices.
- Asserts done when the full matrix has been written.
- Feeds the A/B operand buffers of the matrix multiplier; it is the input counterpart of the result writer.

---
 rtl/matrix_reader.sv | 130 +++++++++++++
 tb/tb_matrix_reader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_reader.sv
// matrix_reader
//   Loads an n x n matrix of 32-bit words, streamed row-major over a
//   valid/ready handshake, into a matrix buffer RAM (one write per word).
//   Feeds the A/B operand buffers of the matrix multiplier.
//
// Build option:
//   MATRIX_READER_TRANSPOSE_EN - when defined, each word is written to
//   {j, i} instead of {i, j}, storing the stream column-major (used to
//   preload the B operand as its transpose). Handshake and timing unchanged.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        begin a load; honoured in IDLE and DONE only
//   in_data      stream word, row-major order
//   in_valid     in_data valid
//   in_ready     block accepts a word this cycle (high in LOAD)
//   mem_we       RAM write strobe, one cycle after each accept
//   mem_addr     RAM word address
//   mem_wdata    RAM write data
//   i, j         row/column index of the next word to accept (n_len+1 bits)
//   busy         high in LOAD
//   done         high in DONE

module matrix_reader #(
  parameter int n     = 8,
  parameter int n_len = $clog2(n)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [2*n_len-1:0]   mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [n_len:0]       i,
  output logic [n_len:0]       j,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [n_len:0] IDX_LAST = (n_len + 1)'(n - 1);
  localparam logic [n_len:0] IDX_ONE  = (n_len + 1)'(1);

  state_t               state_q, state_d;
  logic [n_len:0]       i_q, i_d;
  logic [n_len:0]       j_q, j_d;
  logic                 we_q, we_d;
  logic [2*n_len-1:0]   addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 accept;
  logic [2*n_len-1:0]   word_addr;

`ifdef MATRIX_READER_TRANSPOSE_EN
  assign word_addr = {j_q[n_len-1:0], i_q[n_len-1:0]};
`else
  assign word_addr = {i_q[n_len-1:0], j_q[n_len-1:0]};
`endif

  assign in_ready = (state_q == LOAD);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          i_d     = '0;
          j_d     = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = word_addr;
          wdata_d = in_data;
          if (j_q == IDX_LAST) begin
            j_d = '0;
            i_d = i_q + IDX_ONE;
            // Last word: i rolls to n and the load completes on this edge.
            if (i_q == IDX_LAST) state_d = DONE;
          end else begin
            j_d = j_q + IDX_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i         = i_q;
  assign j         = j_q;
  assign busy      = (state_q == LOAD);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_matrix_reader.sv
// tb_matrix_reader
//   Directed bench for matrix_reader with n=4: full loads, bubbled loads,
//   IDLE input ignoring, async reset mid-load and back-to-back restarts.
//   Address expectations follow MATRIX_READER_TRANSPOSE_EN when defined.

module tb_matrix_reader;

  localparam int N   = 4;
  localparam int NL  = 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [2*NL-1:0]   mem_addr;
  logic [31:0]       mem_wdata;
  logic [NL:0]       i;
  logic [NL:0]       j;
  logic              busy;
  logic              done;

  int unsigned total;
  int unsigned bad;

  matrix_reader #(.n(N), .n_len(NL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .i         (i),
    .j         (j),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Hand-derived target address of the k-th streamed word.
  function automatic logic [31:0] exp_addr(input int unsigned k);
`ifdef MATRIX_READER_TRANSPOSE_EN
    return 32'((k % N) * N + k / N);
`else
    return 32'(k);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start    = 1'b1;
    in_valid = 1'b0;
    tick();
    start    = 1'b0;
    chk("start_busy",  32'(busy), 32'd1);
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_done",  32'(done), 32'd0);
    chk("start_we",    32'(mem_we), 32'd0);
    chk("start_i",     32'(i), 32'd0);
    chk("start_j",     32'(j), 32'd0);
  endtask

  // Streams words first..first+count-1 of a load; optional bubble after each.
  task automatic run_words(input logic [31:0] base, input int unsigned first,
                           input int unsigned count, input bit gaps);
    for (int unsigned k = first; k < first + count; k++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(k);
      tick();
      in_valid = 1'b0;
      in_data  = 32'hDEAD_BEEF;
      chk("we",    32'(mem_we), 32'd1);
      chk("addr",  32'(mem_addr), exp_addr(k));
      chk("wdata", mem_wdata, base + 32'(k));
      chk("i",     32'(i), 32'((k + 1) / N));
      chk("j",     32'(j), 32'((k + 1) % N));
      chk("done",  32'(done), 32'(k == N * N - 1));
      chk("ready", 32'(in_ready), 32'(k != N * N - 1));
      if (gaps) begin
        tick();
        chk("gap_we",   32'(mem_we), 32'd0);
        chk("gap_i",    32'(i), 32'((k + 1) / N));
        chk("gap_j",    32'(j), 32'((k + 1) % N));
        chk("gap_done", 32'(done), 32'(k == N * N - 1));
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_i",     32'(i), 32'd0);
    chk("rst_j",     32'(j), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full load, valid held high.
    do_start();
    run_words(32'h100, 0, 16, 1'b0);
    chk("full_i_end", 32'(i), 32'd4);
    chk("full_busy",  32'(busy), 32'd0);

    // Restart straight from DONE with a second stream.
    do_start();
    run_words(32'h200, 0, 16, 1'b0);
    tick();
    chk("done_hold",   32'(done), 32'd1);
    chk("done_we_off", 32'(mem_we), 32'd0);
    chk("done_i",      32'(i), 32'd4);
    chk("done_j",      32'(j), 32'd0);

    // Reset, then valid without start in IDLE is ignored.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = 32'h55;
      tick();
      chk("idle_ready", 32'(in_ready), 32'd0);
      chk("idle_we",    32'(mem_we), 32'd0);
      chk("idle_i",     32'(i), 32'd0);
      chk("idle_j",     32'(j), 32'd0);
    end
    in_valid = 1'b0;

    // Load with a bubble after every word.
    do_start();
    run_words(32'h100, 0, 16, 1'b1);

    // Async reset after 7 accepts, checked between clock edges.
    do_start();
    run_words(32'h300, 0, 7, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_we",    32'(mem_we), 32'd0);
    chk("mid_addr",  32'(mem_addr), 32'd0);
    chk("mid_wdata", mem_wdata, 32'd0);
    chk("mid_i",     32'(i), 32'd0);
    chk("mid_j",     32'(j), 32'd0);
    chk("mid_busy",  32'(busy), 32'd0);
    chk("mid_ready", 32'(in_ready), 32'd0);
    chk("mid_done",  32'(done), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(in_ready), 32'd0);
    do_start();
    run_words(32'h000, 0, 16, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
